// File: rtl/datapath_sequencer.sv
// Multi-cycle instruction sequencer: handshake, decode, operand read,
// optional Rs read, timed execute and write-back, with Moore strobes.
module datapath_sequencer #(
    parameter int ALU_CYCLES  = 2,
    parameter int MULT_CYCLES = 4
) (
    input  logic        clk1,
    input  logic        rst,
    input  logic        instr_valid,
    input  logic [31:0] instr_in,
    output logic        instr_ready,
    input  logic        is_immediate,
    input  logic        immediate_shift,
    input  logic        reg_w_req,
    input  logic        set_flags,
    input  logic        alu_hot,
    input  logic        mult_hot,
    output logic [31:0] instruction,
    output logic        decode_en,
    output logic [1:0]  rf_addr_sel,
    output logic        operand_latch,
    output logic        shift_count_src,
    output logic        alu_active,
    output logic        mult_active,
    output logic        reg_w,
    output logic        cpsr_w,
    output logic        done,
    output logic [2:0]  state,
    output logic [15:0] retired_count
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DECODE = 3'd1,
        READ   = 3'd2,
        RSREAD = 3'd3,
        EXEC   = 3'd4,
        WB     = 3'd5
    } state_t;

    // Zero-length execute is meaningless; stretch it to one cycle.
    localparam logic [3:0] ALU_LEN  = (ALU_CYCLES  < 1) ? 4'd1 : 4'(ALU_CYCLES);
    localparam logic [3:0] MULT_LEN = (MULT_CYCLES < 1) ? 4'd1 : 4'(MULT_CYCLES);

    state_t     cur;
    state_t     nxt;
    logic [3:0] cnt;
    logic [3:0] exec_len;
    logic       enter_exec;

    assign state       = cur;
    assign instr_ready = (cur == IDLE) && !rst;
    assign enter_exec  = (nxt == EXEC) && (cur != EXEC);

    always_comb begin
        nxt      = cur;
        exec_len = 4'd1;
        if (mult_hot) begin
            exec_len = MULT_LEN;
        end else if (alu_hot) begin
            exec_len = ALU_LEN;
        end
        unique case (cur)
            IDLE:    if (instr_valid) nxt = DECODE;
            DECODE:  nxt = READ;
            READ:    nxt = (!is_immediate && !immediate_shift) ? RSREAD : EXEC;
            RSREAD:  nxt = EXEC;
            EXEC:    if (cnt <= 4'd1) nxt = WB;
            WB:      nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            cur             <= IDLE;
            instruction     <= '0;
            cnt             <= '0;
            retired_count   <= '0;
            decode_en       <= 1'b0;
            rf_addr_sel     <= 2'd0;
            operand_latch   <= 1'b0;
            shift_count_src <= 1'b0;
            alu_active      <= 1'b0;
            mult_active     <= 1'b0;
            reg_w           <= 1'b0;
            cpsr_w          <= 1'b0;
            done            <= 1'b0;
        end else begin
            cur <= nxt;
            if (cur == IDLE && instr_valid) begin
                instruction <= instr_in;
            end
            if (enter_exec) begin
                cnt <= exec_len;
            end else if (cur == EXEC && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
            // Strobes are registered from the next state so they line up with it.
            decode_en     <= (nxt == DECODE);
            operand_latch <= (nxt == READ);
            rf_addr_sel   <= (nxt == RSREAD) ? 2'd1 :
                             (nxt == WB)     ? 2'd2 : 2'd0;
            shift_count_src <= (nxt == RSREAD) ||
                               ((nxt == EXEC) &&
                                ((cur == RSREAD) ||
                                 ((cur == EXEC) && shift_count_src)));
            alu_active  <= (nxt == EXEC) &&
                           (enter_exec ? (alu_hot && !mult_hot) : alu_active);
            mult_active <= (nxt == EXEC) &&
                           (enter_exec ? mult_hot : mult_active);
            reg_w  <= (nxt == WB) && reg_w_req;
            cpsr_w <= (nxt == WB) && reg_w_req && set_flags;
            done   <= (nxt == WB);
            if (nxt == WB) begin
                retired_count <= retired_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_datapath_sequencer.sv
// Directed table-driven bench for datapath_sequencer plus reset-abort
// and retire-counter wrap sequences.
module tb_datapath_sequencer;

    logic        clk1 = 1'b0;
    logic        rst;
    logic        instr_valid;
    logic [31:0] instr_in;
    logic        instr_ready;
    logic        is_immediate;
    logic        immediate_shift;
    logic        reg_w_req;
    logic        set_flags;
    logic        alu_hot;
    logic        mult_hot;
    logic [31:0] instruction;
    logic        decode_en;
    logic [1:0]  rf_addr_sel;
    logic        operand_latch;
    logic        shift_count_src;
    logic        alu_active;
    logic        mult_active;
    logic        reg_w;
    logic        cpsr_w;
    logic        done;
    logic [2:0]  state;
    logic [15:0] retired_count;

    datapath_sequencer #(.ALU_CYCLES(2), .MULT_CYCLES(4)) dut (
        .clk1            (clk1),
        .rst             (rst),
        .instr_valid     (instr_valid),
        .instr_in        (instr_in),
        .instr_ready     (instr_ready),
        .is_immediate    (is_immediate),
        .immediate_shift (immediate_shift),
        .reg_w_req       (reg_w_req),
        .set_flags       (set_flags),
        .alu_hot         (alu_hot),
        .mult_hot        (mult_hot),
        .instruction     (instruction),
        .decode_en       (decode_en),
        .rf_addr_sel     (rf_addr_sel),
        .operand_latch   (operand_latch),
        .shift_count_src (shift_count_src),
        .alu_active      (alu_active),
        .mult_active     (mult_active),
        .reg_w           (reg_w),
        .cpsr_w          (cpsr_w),
        .done            (done),
        .state           (state),
        .retired_count   (retired_count)
    );

    always #5 clk1 = ~clk1;

    typedef struct {
        logic [31:0] instr;
        logic        imm;
        logic        ish;
        logic        rw;
        logic        s;
        logic        alu;
        logic        mult;
        int          lat;
        int          alu_n;
        int          mult_n;
        int          rs_n;
        int          scs_n;
        int          rw_n;
        int          cw_n;
        logic [31:0] trace;
    } vec_t;

    vec_t        vt[7];
    int          vectors = 0;
    int          misses  = 0;
    logic [15:0] exp_ret;

    task automatic step();
        @(posedge clk1);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            misses++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int          lat;
        int          alu_n;
        int          mult_n;
        int          rs_n;
        int          scs_n;
        int          rw_n;
        int          cw_n;
        int          both;
        int          rdy;
        logic [31:0] trace;
        lat = 0; alu_n = 0; mult_n = 0; rs_n = 0; scs_n = 0;
        rw_n = 0; cw_n = 0; both = 0; rdy = 0; trace = 0;
        instr_in        = v.instr;
        is_immediate    = v.imm;
        immediate_shift = v.ish;
        reg_w_req       = v.rw;
        set_flags       = v.s;
        alu_hot         = v.alu;
        mult_hot        = v.mult;
        instr_valid     = 1'b1;
        check($sformatf("v%0d_ready_idle", idx), 32'(instr_ready), 32'd1);
        step();
        instr_in = ~v.instr;
        for (int k = 1; k <= 40; k++) begin
            trace  = (trace << 4) | 32'(state);
            alu_n  += int'(alu_active);
            mult_n += int'(mult_active);
            both   += int'(alu_active && mult_active);
            rs_n   += int'(state == 3'd3);
            scs_n  += int'(shift_count_src);
            rw_n   += int'(reg_w);
            cw_n   += int'(cpsr_w);
            rdy    += int'(instr_ready);
            if (done) begin
                lat = k;
                break;
            end
            step();
        end
        exp_ret = exp_ret + 16'd1;
        check($sformatf("v%0d_latency", idx), 32'(lat), 32'(v.lat));
        check($sformatf("v%0d_trace", idx), trace, v.trace);
        check($sformatf("v%0d_alu_cycles", idx), 32'(alu_n), 32'(v.alu_n));
        check($sformatf("v%0d_mult_cycles", idx), 32'(mult_n), 32'(v.mult_n));
        check($sformatf("v%0d_both_active", idx), 32'(both), 32'd0);
        check($sformatf("v%0d_rsread", idx), 32'(rs_n), 32'(v.rs_n));
        check($sformatf("v%0d_scs_cycles", idx), 32'(scs_n), 32'(v.scs_n));
        check($sformatf("v%0d_reg_w", idx), 32'(rw_n), 32'(v.rw_n));
        check($sformatf("v%0d_cpsr_w", idx), 32'(cw_n), 32'(v.cw_n));
        check($sformatf("v%0d_instruction", idx), instruction, v.instr);
        check($sformatf("v%0d_retired", idx), 32'(retired_count), 32'(exp_ret));
        check($sformatf("v%0d_ready_busy", idx), 32'(rdy), 32'd0);
        step();
        check($sformatf("v%0d_back_idle", idx), 32'(state), 32'd0);
    endtask

    initial begin
        // instr, imm, ish, rw, s, alu, mult, lat, alu, mult, rs, scs, rw, cw, trace
        vt[0] = '{32'h0290000F, 1, 0, 1, 1, 1, 0, 5, 2, 0, 0, 0, 1, 1, 32'h00012445};
        vt[1] = '{32'h00100211, 0, 0, 1, 0, 1, 0, 6, 2, 0, 1, 3, 1, 0, 32'h00123445};
        vt[2] = '{32'h00000091, 1, 0, 1, 1, 1, 1, 7, 0, 4, 0, 0, 1, 1, 32'h01244445};
        vt[3] = '{32'h01A00100, 0, 1, 0, 1, 0, 0, 4, 0, 0, 0, 0, 0, 0, 32'h00001245};
        vt[4] = '{32'h00010392, 0, 0, 1, 0, 1, 1, 8, 0, 4, 1, 5, 1, 0, 32'h12344445};
        vt[5] = '{32'h00810101, 0, 1, 1, 1, 1, 0, 5, 2, 0, 0, 0, 1, 1, 32'h00012445};
        vt[6] = '{32'h01A00312, 0, 0, 1, 1, 0, 0, 5, 0, 0, 1, 2, 1, 1, 32'h00012345};

        rst             = 1'b1;
        instr_valid     = 1'b0;
        instr_in        = 32'hDEADBEEF;
        is_immediate    = 1'b0;
        immediate_shift = 1'b0;
        reg_w_req       = 1'b0;
        set_flags       = 1'b0;
        alu_hot         = 1'b0;
        mult_hot        = 1'b0;
        exp_ret         = 16'd0;
        step();
        step();
        check("rst_state", 32'(state), 32'd0);
        check("rst_instruction", instruction, 32'd0);
        check("rst_retired", 32'(retired_count), 32'd0);
        check("rst_strobes",
              32'({decode_en, operand_latch, shift_count_src, alu_active,
                   mult_active, reg_w, cpsr_w, done}), 32'd0);
        check("rst_addr_sel", 32'(rf_addr_sel), 32'd0);
        rst = 1'b0;
        #1;
        check("ready_after_rst", 32'(instr_ready), 32'd1);

        // Abort in the second execute cycle of an immediate ALU op.
        instr_in     = vt[0].instr;
        is_immediate = 1'b1;
        reg_w_req    = 1'b1;
        set_flags    = 1'b1;
        alu_hot      = 1'b1;
        instr_valid  = 1'b1;
        step();
        instr_valid = 1'b0;
        step();
        step();
        step();
        check("abort_pre_state", 32'(state), 32'd4);
        check("abort_pre_alu", 32'(alu_active), 32'd1);
        rst = 1'b1;
        #1;
        check("abort_state", 32'(state), 32'd0);
        check("abort_strobes",
              32'({done, reg_w, cpsr_w, alu_active}), 32'd0);
        #1;
        rst = 1'b0;
        begin
            int pulses;
            pulses = 0;
            for (int k = 0; k < 8; k++) begin
                step();
                pulses += int'(done || reg_w || cpsr_w);
            end
            check("abort_no_done", 32'(pulses), 32'd0);
        end
        check("abort_retired", 32'(retired_count), 32'd0);
        check("abort_idle", 32'(state), 32'd0);

        // Back-to-back: instr_valid stays high through the whole table.
        for (int i = 0; i < 7; i++) begin
            run_vec(vt[i], i);
        end
        instr_valid = 1'b0;
        step();

        force dut.retired_count = 16'hFFFF;
        step();
        release dut.retired_count;
        #1;
        exp_ret = 16'hFFFF;
        check("wrap_preload", 32'(retired_count), 32'h0000FFFF);
        run_vec(vt[3], 7);
        check("wrap_zero", 32'(retired_count), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
        $finish;
    end

endmodule
